// File: rtl/q_seq_pkg.sv
// q_seq_pkg -- shared definitions for the serial stage sequencer.
//
// Holds the sequencer FSM state type and the default operand width and
// stage latency used by q_stage_seq.

package q_seq_pkg;

    // Default operand/result width in bits.
    localparam int unsigned DefWidth = 8;

    // Default stage latency: cycles from a bit on stg_pi/stg_si to its
    // result on stg_po/stg_so/stg_f.
    localparam int unsigned DefStageLat = 2;

    // Sequencer states. StDrain is bypassed when the stage latency is zero.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/q_seq_arb.sv
// q_seq_arb -- two-requester arbiter for q_stage_seq.
//
// Purely combinational. The grant is only consumed by the sequencer while
// it is idle, so the arbiter carries no state of its own.
//
// Configuration macro: QSEQ_RR_EN
//   defined   : round-robin; on a tie the requester not served last wins.
//   undefined : fixed priority; req0 always wins, last_id is ignored.
//
// Ports
//   req0, req1 : level requests from requester 0/1
//   last_id    : id of the requester served by the previous transaction
//   gnt_id     : id of the winning requester (valid only with gnt_valid)
//   gnt_valid  : at least one request is pending

module q_seq_arb (
    input  logic req0,
    input  logic req1,
    input  logic last_id,
    output logic gnt_id,
    output logic gnt_valid
);

`ifdef QSEQ_RR_EN
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            // Tie: hand the grant to whoever did not get the last one.
            gnt_id = ~last_id;
        end else begin
            gnt_id = req1;
        end
    end
`else
    // The pointer is meaningless under fixed priority.
    logic unused_last;
    assign unused_last = last_id;

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = req1 & ~req0;
    end
`endif

endmodule

// File: rtl/q_stage_seq.sv
// q_stage_seq -- sequencer that serialises an operand pair through an
// external bit-serial stage on behalf of one of two requesters.
//
// A granted transaction runs IDLE -> START -> SHIFT -> DRAIN -> DONE -> IDLE.
// START pulses stg_start with stg_rst held; SHIFT drives a/b LSB first on
// stg_pi/stg_si for WIDTH cycles; DRAIN waits STAGE_LAT cycles for the stage
// pipeline to empty (skipped when STAGE_LAT is 0). The stage outputs are
// collected STAGE_LAT cycles behind the driven bits and presented at DONE
// together with a one-cycle ack to the owning requester. The request-to-DONE
// latency is WIDTH + STAGE_LAT + 2 cycles.
//
// Configuration macro: QSEQ_RR_EN
//   defined   : round-robin arbitration, pointer updated at DONE.
//   undefined : fixed priority, requester 0 always wins.
//
// Parameters
//   WIDTH     : operand/result width in bits (>= 2)
//   STAGE_LAT : stage latency in cycles (0..7)
//
// Ports
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   req0, req1          : level requests
//   a0, b0, a1, b1      : operands of requester 0/1, captured at grant
//   ack0, ack1          : one-cycle completion pulse to requester 0/1
//   res_po, res_so      : collected stg_po/stg_so bits, held until next DONE
//   res_f               : OR of all sampled stg_f bits
//   res_id              : owner of the presented result
//   res_valid           : high during the DONE cycle
//   stg_start, stg_rst  : stage control
//   stg_pi, stg_si      : serial operand bits to the stage
//   stg_po, stg_so      : serial result bits from the stage
//   stg_f               : stage flag

module q_stage_seq
    import q_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned STAGE_LAT = DefStageLat
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res_po,
    output logic [WIDTH-1:0] res_so,
    output logic             res_f,
    output logic             res_id,
    output logic             res_valid,
    output logic             stg_start,
    output logic             stg_rst,
    output logic             stg_pi,
    output logic             stg_si,
    input  logic             stg_po,
    input  logic             stg_so,
    input  logic             stg_f
);

    // One counter spans SHIFT and DRAIN: c = 0 .. WIDTH+STAGE_LAT-1.
    localparam int unsigned CntW = $clog2(WIDTH + STAGE_LAT + 1);

    localparam logic [CntW-1:0] ShiftLast   = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] RunLast     = CntW'(WIDTH + STAGE_LAT - 1);
    localparam logic [CntW-1:0] SampleFirst = CntW'(STAGE_LAT);

    state_e            state_q;
    logic              owner_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  po_acc_q;
    logic [WIDTH-1:0]  so_acc_q;
    logic              f_acc_q;

    logic              gnt_id;
    logic              gnt_valid;
    logic              last_id;

    logic [WIDTH-1:0]  po_next;
    logic [WIDTH-1:0]  so_next;
    logic              f_next;
    logic              sample_en;

    q_seq_arb u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_id   (last_id),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

`ifdef QSEQ_RR_EN
    // Reset as if requester 1 was served last, so the first tie goes to
    // requester 0.
    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (state_q == StDone) begin
            last_q <= owner_q;
        end
    end

    assign last_id = last_q;
`else
    assign last_id = 1'b1;
`endif

    // Samples enter at the MSB and move down, so after WIDTH samples the
    // first one sits in bit 0.
    always_comb begin
        po_next   = {stg_po, po_acc_q[WIDTH-1:1]};
        so_next   = {stg_so, so_acc_q[WIDTH-1:1]};
        f_next    = f_acc_q | stg_f;
        sample_en = (cnt_q >= SampleFirst);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            po_acc_q  <= '0;
            so_acc_q  <= '0;
            f_acc_q   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res_po    <= '0;
            res_so    <= '0;
            res_f     <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            stg_start <= 1'b0;
            stg_rst   <= 1'b1;
            stg_pi    <= 1'b0;
            stg_si    <= 1'b0;
        end else begin
            // Single-cycle pulses.
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res_valid <= 1'b0;
            stg_start <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        state_q   <= StStart;
                        owner_q   <= gnt_id;
                        a_sh_q    <= gnt_id ? a1 : a0;
                        b_sh_q    <= gnt_id ? b1 : b0;
                        stg_start <= 1'b1;
                        stg_rst   <= 1'b1;
                    end
                end

                StStart: begin
                    state_q  <= StShift;
                    cnt_q    <= '0;
                    po_acc_q <= '0;
                    so_acc_q <= '0;
                    f_acc_q  <= 1'b0;
                    stg_rst  <= 1'b0;
                    stg_pi   <= a_sh_q[0];
                    stg_si   <= b_sh_q[0];
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                end

                StShift, StDrain: begin
                    if (sample_en) begin
                        po_acc_q <= po_next;
                        so_acc_q <= so_next;
                        f_acc_q  <= f_next;
                    end

                    // Next serial bit; zeros once the operand is exhausted.
                    if (state_q == StShift && cnt_q != ShiftLast) begin
                        stg_pi <= a_sh_q[0];
                        stg_si <= b_sh_q[0];
                        a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                        b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    end else begin
                        stg_pi <= 1'b0;
                        stg_si <= 1'b0;
                    end

                    // RunLast equals ShiftLast when STAGE_LAT is 0, so this
                    // check comes first and DRAIN is skipped.
                    if (cnt_q == RunLast) begin
                        state_q   <= StDone;
                        stg_rst   <= 1'b1;
                        res_valid <= 1'b1;
                        res_id    <= owner_q;
                        ack0      <= ~owner_q;
                        ack1      <= owner_q;
                        res_po    <= po_next;
                        res_so    <= so_next;
                        res_f     <= f_next;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == ShiftLast) begin
                            state_q <= StDrain;
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                    stg_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_stage_seq.sv
// tb_q_stage_seq -- self-checking bench for q_stage_seq (WIDTH=8,
// STAGE_LAT=2). A behavioural stage echoes stg_pi/stg_si to stg_po/stg_so
// two cycles later and raises stg_f two cycles after any cycle where both
// serial bits are 1 while f_en is set. Expected results are derived from
// the transaction rules: res_po=a, res_so=b, res_f=f_en && |(a&b).

module tb_q_stage_seq;

    localparam int W   = 8;
    localparam int L   = 2;
    localparam int LAT = W + L + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         ack0, ack1, res_f, res_id, res_valid;
    logic [W-1:0] res_po, res_so;
    logic         stg_start, stg_rst, stg_pi, stg_si, stg_po, stg_so, stg_f;

    int n_checks = 0;
    int n_fail   = 0;
    bit f_en     = 1'b0;

    always #5 clk = ~clk;

    q_stage_seq #(
        .WIDTH     (W),
        .STAGE_LAT (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .res_po    (res_po),
        .res_so    (res_so),
        .res_f     (res_f),
        .res_id    (res_id),
        .res_valid (res_valid),
        .stg_start (stg_start),
        .stg_rst   (stg_rst),
        .stg_pi    (stg_pi),
        .stg_si    (stg_si),
        .stg_po    (stg_po),
        .stg_so    (stg_so),
        .stg_f     (stg_f)
    );

    // Behavioural stage: L-cycle delay line.
    logic [L-1:0] po_pipe = '0, so_pipe = '0, f_pipe = '0;
    always @(posedge clk) begin
        po_pipe <= {po_pipe[L-2:0], stg_pi};
        so_pipe <= {so_pipe[L-2:0], stg_si};
        f_pipe  <= {f_pipe[L-2:0], stg_pi & stg_si & f_en};
    end
    assign stg_po = po_pipe[L-1];
    assign stg_so = so_pipe[L-1];
    assign stg_f  = f_pipe[L-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge while the DUT is idle with requests already set.
    // Walks negedges k=1.. until an ack, recording the serial bits seen in
    // the SHIFT slots and counting stage-control values outside the schedule.
    task automatic run_one(input bit chg, input bit drop_drain, input bit hold,
                           output int lat, output int id_seen,
                           output logic [W-1:0] pi_seen, output logic [W-1:0] si_seen,
                           output int sched_bad);
        lat = -1; id_seen = -1; pi_seen = '0; si_seen = '0; sched_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (stg_start !== 1'b1 || stg_rst !== 1'b1) sched_bad++;
                if (chg) begin
                    a0 = ~a0; a1 = ~a1; b0 = ~b0; b1 = ~b1;
                end
            end else if (k <= W + 1) begin
                pi_seen[k-2] = stg_pi;
                si_seen[k-2] = stg_si;
                if (stg_rst !== 1'b0 || stg_start !== 1'b0) sched_bad++;
            end else if (k <= W + L + 1) begin
                if (stg_rst !== 1'b0 || stg_pi !== 1'b0 || stg_si !== 1'b0) sched_bad++;
                if (drop_drain && k == W + 2) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                lat = k;
                id_seen = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                if (stg_rst !== 1'b1) sched_bad++;
                if (!hold) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] ctl;
        repeat (2) @(negedge clk);
        ctl = {ack0, ack1, res_valid, res_id, res_f, stg_start, stg_rst, stg_pi, stg_si};
        n_checks++;
        if (ctl !== 9'b000000100) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 9'b000000100);
        end
        n_checks++;
        if ({res_po, res_so} !== 16'h0) begin
            n_fail++; $display("FAIL reset_res: got %h want 0000", {res_po, res_so});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ack0, ack1, stg_start, stg_rst} !== 4'b0001) begin
                n_fail++;
                $display("FAIL idle_noreq: got %b want 0001", {ack0, ack1, stg_start, stg_rst});
            end
        end
    endtask

    task automatic test_basic();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        a0 = 8'hA5; b0 = 8'h3C; a1 = W'($urandom); b1 = W'($urandom); f_en = 1'b0;
        req0 = 1'b1;
        run_one(1'b0, 1'b0, 1'b0, lat, id, pis, sis, bad);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT); end
        n_checks++;
        if (id != 0) begin n_fail++; $display("FAIL basic_ack: got id %0d want 0", id); end
        n_checks++;
        if ({res_po, res_so} !== 16'hA53C) begin
            n_fail++; $display("FAIL basic_res: got %h want a53c", {res_po, res_so});
        end
        n_checks++;
        if ({res_id, res_valid, res_f} !== 3'b010) begin
            n_fail++; $display("FAIL basic_flags: got %b want 010", {res_id, res_valid, res_f});
        end
        n_checks++;
        if ({pis, sis} !== 16'hA53C) begin
            n_fail++; $display("FAIL basic_serial: got %h want a53c", {pis, sis});
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_sched: got %0d bad want 0", bad); end
    endtask

    task automatic test_hold();
        a0 = 8'h00; b0 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({res_po, res_so, res_valid, ack0, ack1} !== {16'hA53C, 3'b000}) begin
                n_fail++;
                $display("FAIL hold: got %h/%b want a53c/000",
                         {res_po, res_so}, {res_valid, ack0, ack1});
            end
        end
    endtask

    task automatic test_flag();
        logic [W-1:0] av [3];
        logic [W-1:0] bv [3];
        bit           fe [3];
        int lat, id; logic [W-1:0] pis, sis; int bad;
        logic exp_f;
        av[0] = 8'h10; bv[0] = 8'h10; fe[0] = 1'b1;   // flag only on 5th sample
        av[1] = 8'hFF; bv[1] = 8'hFF; fe[1] = 1'b0;   // stage flag never set
        av[2] = 8'h0F; bv[2] = 8'hF0; fe[2] = 1'b1;   // no overlapping ones
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a0 = av[i]; b0 = bv[i]; f_en = fe[i]; req0 = 1'b1;
            run_one(1'b0, 1'b0, 1'b0, lat, id, pis, sis, bad);
            exp_f = fe[i] && ((av[i] & bv[i]) != '0);
            n_checks++;
            if (res_f !== exp_f) begin
                n_fail++; $display("FAIL flag_%0d: got %b want %b", i, res_f, exp_f);
            end
            n_checks++;
            if (res_po !== av[i] || lat != LAT) begin
                n_fail++;
                $display("FAIL flag_res_%0d: got %h lat %0d want %h lat %0d",
                         i, res_po, lat, av[i], LAT);
            end
        end
        f_en = 1'b0;
    endtask

    task automatic test_random();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        int who; logic [W-1:0] ea, eb; logic ef;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            who = int'($urandom_range(0, 1));
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            f_en = 1'($urandom);
            ea = who ? a1 : a0; eb = who ? b1 : b0;
            ef = f_en && ((ea & eb) != '0);
            if (who == 1) req1 = 1'b1; else req0 = 1'b1;
            run_one(1'b0, 1'b0, 1'b0, lat, id, pis, sis, bad);
            n_checks++;
            if (lat != LAT || id != who || res_id !== 1'(who)) begin
                n_fail++;
                $display("FAIL rand_%0d_ctl: got lat %0d ack %0d id %b want lat %0d id %0d",
                         i, lat, id, res_id, LAT, who);
            end
            n_checks++;
            if ({res_po, res_so, res_f} !== {ea, eb, ef}) begin
                n_fail++;
                $display("FAIL rand_%0d_res: got %h %h %b want %h %h %b",
                         i, res_po, res_so, res_f, ea, eb, ef);
            end
            n_checks++;
            if ({pis, sis} !== {ea, eb} || bad != 0) begin
                n_fail++;
                $display("FAIL rand_%0d_serial: got %h %h bad %0d want %h %h bad 0",
                         i, pis, sis, bad, ea, eb);
            end
        end
        f_en = 1'b0;
    endtask

    task automatic test_operand_change();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        @(negedge clk);
        a0 = 8'h5A; b0 = 8'hC3; req0 = 1'b1;
        run_one(1'b1, 1'b0, 1'b0, lat, id, pis, sis, bad);
        n_checks++;
        if ({pis, sis} !== 16'h5AC3) begin
            n_fail++; $display("FAIL opchg_serial: got %h want 5ac3", {pis, sis});
        end
        n_checks++;
        if ({res_po, res_so} !== 16'h5AC3) begin
            n_fail++; $display("FAIL opchg_res: got %h want 5ac3", {res_po, res_so});
        end
    endtask

    task automatic test_drain_drop();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        logic [W-1:0] ea;
        @(negedge clk);
        a1 = W'($urandom); b1 = W'($urandom); ea = a1; req1 = 1'b1;
        run_one(1'b0, 1'b1, 1'b0, lat, id, pis, sis, bad);
        n_checks++;
        if (lat != LAT || id != 1 || res_id !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ack: got lat %0d ack %0d id %b want lat %0d ack 1 id 1",
                     lat, id, res_id, LAT);
        end
        n_checks++;
        if (res_po !== ea) begin
            n_fail++; $display("FAIL drop_res: got %h want %h", res_po, ea);
        end
    endtask

    task automatic test_back_to_back();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        int exp_id; logic [W-1:0] ea;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        a0 = W'($urandom); b0 = W'($urandom); a1 = ~a0; b1 = W'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef QSEQ_RR_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            ea = exp_id ? a1 : a0;
            run_one(1'b0, 1'b0, 1'b1, lat, id, pis, sis, bad);
            n_checks++;
            if (id != exp_id || lat != LAT || res_po !== ea) begin
                n_fail++;
                $display("FAIL b2b_%0d: got ack %0d lat %0d po %h want ack %0d lat %0d po %h",
                         i, id, lat, res_po, exp_id, LAT, ea);
            end
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, id; logic [W-1:0] pis, sis; int bad;
        int acks;
        logic [11:0] ctl;
        @(negedge clk);
        a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
        repeat (5) @(negedge clk);   // k=5 is SHIFT cycle 3
        rst = 1'b0; req0 = 1'b0;
        #1;
        ctl = {ack0, ack1, res_valid, res_id, res_f, stg_start, stg_rst, stg_pi, stg_si, 3'b000};
        n_checks++;
        if (ctl !== 12'b000000100000) begin
            n_fail++; $display("FAIL midrst_ctl: got %b want 000000100000", ctl);
        end
        n_checks++;
        if ({res_po, res_so} !== 16'h0) begin
            n_fail++; $display("FAIL midrst_res: got %h want 0000", {res_po, res_so});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL midrst_noack: got %0d acks want 0", acks); end
        a0 = 8'hC6; b0 = 8'h71; req0 = 1'b1;
        run_one(1'b0, 1'b0, 1'b0, lat, id, pis, sis, bad);
        n_checks++;
        if (lat != LAT || id != 0 || {res_po, res_so} !== 16'hC671 || bad != 0) begin
            n_fail++;
            $display("FAIL midrst_resume: got lat %0d ack %0d res %h bad %0d want %0d 0 c671 0",
                     lat, id, {res_po, res_so}, bad, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flag();
        test_random();
        test_operand_change();
        test_drain_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
